// File: rtl/frwd_pkg.sv
// rtl/frwd_pkg.sv - shared defaults and history-slot type for the operand bypass stage
package frwd_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    // History slots carry addresses at this width so REG_AW can vary up to 256 registers
    localparam int HIST_AW    = 8;
    localparam int OP2_LINK   = 4;

    typedef struct packed {
        logic               valid;
        logic [HIST_AW-1:0] addr;
    } hist_slot_t;

endpackage

// File: rtl/bypass_match.sv
// rtl/bypass_match.sv - youngest-match priority compare and data select for one source operand
module bypass_match
    import frwd_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = 3
) (
    input  hist_slot_t [DEPTH-1:0]      i_hist,
    input  logic       [REG_AW-1:0]     i_src_addr,
    input  logic       [XLEN-1:0]       i_rf_data,
    input  logic       [DEPTH*XLEN-1:0] i_stg_data,
    input  logic       [DEPTH-1:0]      i_stg_rdy,
    output logic       [XLEN-1:0]       o_data,
    output logic                        o_hit,
    output logic                        o_rdy
);

    // Walk oldest to youngest so the lowest matching slot overwrites older ones
    always_comb begin
        o_data = i_rf_data;
        o_hit  = 1'b0;
        o_rdy  = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_hist[k].valid && (i_hist[k].addr == HIST_AW'(i_src_addr)) &&
                (i_src_addr != '0)) begin
                o_data = i_stg_data[k*XLEN +: XLEN];
                o_hit  = 1'b1;
                o_rdy  = i_stg_rdy[k];
            end
        end
    end

endmodule

// File: rtl/op_bypass.sv
// rtl/op_bypass.sv - ID/EX operand bypass, load-use stall and ID/EX register; OP_BYPASS_STATS_EN enables counters
module op_bypass
    import frwd_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_id_valid,
    output logic                    o_id_ready,
    input  logic [REG_AW-1:0]       i_rs1_addr,
    input  logic [REG_AW-1:0]       i_rs2_addr,
    input  logic                    i_rs1_used,
    input  logic                    i_rs2_used,
    input  logic [XLEN-1:0]         i_rs1_rdata,
    input  logic [XLEN-1:0]         i_rs2_rdata,
    input  logic                    i_auipc,
    input  logic                    i_imm,
    input  logic                    i_jal,
    input  logic                    i_jalr,
    input  logic [XLEN-1:0]         i_pc,
    input  logic [XLEN-1:0]         i_immediate,
    input  logic [REG_AW-1:0]       i_rd_addr,
    input  logic                    i_rd_we,
    input  logic                    i_mem_reg,
    input  logic                    i_ex_ready,
    input  logic                    i_flush,
    input  logic [DEPTH*XLEN-1:0]   i_stg_data,
    input  logic [DEPTH-1:0]        i_stg_rdy,
    output logic                    o_ex_valid,
    output logic [XLEN-1:0]         o_op1,
    output logic [XLEN-1:0]         o_op2,
    output logic [XLEN-1:0]         o_rs2_fwd,
    output logic [REG_AW-1:0]       o_rd_addr,
    output logic                    o_rd_we,
    output logic                    o_mem_reg,
    output logic [31:0]             o_stall_cnt,
    output logic [31:0]             o_fwd_cnt
);

    logic              ex_valid_d, ex_valid_q;
    logic [XLEN-1:0]   op1_d, op1_q;
    logic [XLEN-1:0]   op2_d, op2_q;
    logic [XLEN-1:0]   rs2_fwd_d, rs2_fwd_q;
    logic [REG_AW-1:0] rd_addr_d, rd_addr_q;
    logic              rd_we_d, rd_we_q;
    logic              mem_reg_d, mem_reg_q;

    hist_slot_t                   slot0;
    hist_slot_t [DEPTH-1:1]       old_d, old_q;
    hist_slot_t [DEPTH-1:0]       hist;

    logic [XLEN-1:0] fwd_rs1, fwd_rs2, op1_sel, op2_sel;
    logic            hit1, hit2, rdy1, rdy2;
    logic            hazard, adv, id_ready, issue;

    // Slot 0 is the instruction currently held in the ID/EX register
    always_comb begin
        slot0.valid = ex_valid_q & rd_we_q;
        slot0.addr  = HIST_AW'(rd_addr_q);
        hist        = {old_q, slot0};
    end

    always_comb begin
        old_d = old_q;
        if (i_ex_ready) begin
            old_d[1] = slot0;
            for (int k = 2; k < DEPTH; k++) begin
                old_d[k] = old_q[k-1];
            end
        end
    end

    bypass_match #(.XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH)) u_match_rs1 (
        .i_hist     (hist),
        .i_src_addr (i_rs1_addr),
        .i_rf_data  (i_rs1_rdata),
        .i_stg_data (i_stg_data),
        .i_stg_rdy  (i_stg_rdy),
        .o_data     (fwd_rs1),
        .o_hit      (hit1),
        .o_rdy      (rdy1)
    );

    bypass_match #(.XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH)) u_match_rs2 (
        .i_hist     (hist),
        .i_src_addr (i_rs2_addr),
        .i_rf_data  (i_rs2_rdata),
        .i_stg_data (i_stg_data),
        .i_stg_rdy  (i_stg_rdy),
        .o_data     (fwd_rs2),
        .o_hit      (hit2),
        .o_rdy      (rdy2)
    );

    always_comb begin
        hazard   = (i_rs1_used & hit1 & ~rdy1) | (i_rs2_used & hit2 & ~rdy2);
        adv      = i_ex_ready | ~ex_valid_q;
        id_ready = ~i_rst & ~hazard & adv;
        issue    = i_id_valid & id_ready & ~i_flush;
        op1_sel  = i_auipc ? i_pc : fwd_rs1;
        if (i_imm) begin
            op2_sel = i_immediate;
        end else if (i_jal | i_jalr) begin
            op2_sel = XLEN'(OP2_LINK);
        end else begin
            op2_sel = fwd_rs2;
        end
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        rs2_fwd_d  = rs2_fwd_q;
        rd_addr_d  = rd_addr_q;
        rd_we_d    = rd_we_q;
        mem_reg_d  = mem_reg_q;
        if (i_flush) begin
            ex_valid_d = 1'b0;
        end else if (adv) begin
            ex_valid_d = issue;
            op1_d      = op1_sel;
            op2_d      = op2_sel;
            rs2_fwd_d  = fwd_rs2;
            rd_addr_d  = i_rd_addr;
            rd_we_d    = i_rd_we;
            mem_reg_d  = i_mem_reg;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid_q <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            rs2_fwd_q  <= '0;
            rd_addr_q  <= '0;
            rd_we_q    <= 1'b0;
            mem_reg_q  <= 1'b0;
            old_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            rs2_fwd_q  <= rs2_fwd_d;
            rd_addr_q  <= rd_addr_d;
            rd_we_q    <= rd_we_d;
            mem_reg_q  <= mem_reg_d;
            old_q      <= old_d;
        end
    end

    assign o_id_ready = id_ready;
    assign o_ex_valid = ex_valid_q;
    assign o_op1      = op1_q;
    assign o_op2      = op2_q;
    assign o_rs2_fwd  = rs2_fwd_q;
    assign o_rd_addr  = rd_addr_q;
    assign o_rd_we    = rd_we_q;
    assign o_mem_reg  = mem_reg_q;

`ifdef OP_BYPASS_STATS_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] fwd_cnt_d, fwd_cnt_q;
    logic [1:0]  fwd_inc;

    always_comb begin
        fwd_inc     = {1'b0, i_rs1_used & hit1} + {1'b0, i_rs2_used & hit2};
        stall_cnt_d = stall_cnt_q + 32'(i_id_valid & hazard);
        fwd_cnt_d   = fwd_cnt_q + (issue ? 32'(fwd_inc) : 32'd0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_fwd_cnt   = fwd_cnt_q;
`else
    assign o_stall_cnt = '0;
    assign o_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_op_bypass.sv
// tb/tb_op_bypass.sv - vector table plus scoreboard bench for op_bypass
module tb_op_bypass;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst, i_id_valid, o_id_ready;
    logic [4:0]  i_rs1_addr, i_rs2_addr, i_rd_addr, o_rd_addr;
    logic        i_rs1_used, i_rs2_used, i_auipc, i_imm, i_jal, i_jalr;
    logic [31:0] i_rs1_rdata, i_rs2_rdata, i_pc, i_immediate;
    logic        i_rd_we, i_mem_reg, i_ex_ready, i_flush;
    logic [95:0] i_stg_data;
    logic [2:0]  i_stg_rdy;
    logic        o_ex_valid, o_rd_we, o_mem_reg;
    logic [31:0] o_op1, o_op2, o_rs2_fwd, o_stall_cnt, o_fwd_cnt;

    op_bypass dut (
        .i_clk(clk), .i_rst(i_rst), .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .i_rs1_used(i_rs1_used),
        .i_rs2_used(i_rs2_used), .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata),
        .i_auipc(i_auipc), .i_imm(i_imm), .i_jal(i_jal), .i_jalr(i_jalr), .i_pc(i_pc),
        .i_immediate(i_immediate), .i_rd_addr(i_rd_addr), .i_rd_we(i_rd_we),
        .i_mem_reg(i_mem_reg), .i_ex_ready(i_ex_ready), .i_flush(i_flush),
        .i_stg_data(i_stg_data), .i_stg_rdy(i_stg_rdy), .o_ex_valid(o_ex_valid),
        .o_op1(o_op1), .o_op2(o_op2), .o_rs2_fwd(o_rs2_fwd), .o_rd_addr(o_rd_addr),
        .o_rd_we(o_rd_we), .o_mem_reg(o_mem_reg), .o_stall_cnt(o_stall_cnt),
        .o_fwd_cnt(o_fwd_cnt)
    );

    typedef struct {
        logic        rst, valid, exr, flush;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, auipc, imm, jal, jalr, we, mem;
        logic [31:0] rd1, rd2, pc, immv;
        logic [95:0] sd;
        logic [2:0]  rdy;
        logic        exp_ready, exp_iss, exp_exv;
        logic [31:0] e_op1, e_op2, e_rs2f;
        int          st, fw;
    } vec_t;

    typedef struct {
        logic [31:0] op1, op2, rs2f;
        logic [4:0]  rd;
        logic        we, mem;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    vec_t tbl[$];
    string names[$];
    int checks = 0;
    int failures = 0;
    int exp_stall = 0;
    int exp_fwd = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    function automatic logic [95:0] sd3(input logic [31:0] s2, input logic [31:0] s1,
                                        input logic [31:0] s0);
        return {s2, s1, s0};
    endfunction

    function automatic vec_t ins(input logic [4:0] rs1, input logic u1, input logic [31:0] rd1,
                                 input logic [4:0] rs2, input logic u2, input logic [31:0] rd2,
                                 input logic [4:0] rd, input logic we);
        vec_t v;
        v = '{default: '0};
        v.valid = 1'b1; v.exr = 1'b1; v.rdy = 3'b111;
        v.rs1 = rs1; v.u1 = u1; v.rd1 = rd1;
        v.rs2 = rs2; v.u2 = u2; v.rd2 = rd2;
        v.rd = rd; v.we = we;
        v.exp_ready = 1'b1; v.exp_iss = 1'b1; v.exp_exv = 1'b1;
        v.e_op1 = rd1; v.e_op2 = rd2; v.e_rs2f = rd2;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        i_rst = v.rst; i_id_valid = v.valid; i_ex_ready = v.exr; i_flush = v.flush;
        i_rs1_addr = v.rs1; i_rs2_addr = v.rs2; i_rs1_used = v.u1; i_rs2_used = v.u2;
        i_rs1_rdata = v.rd1; i_rs2_rdata = v.rd2; i_auipc = v.auipc; i_imm = v.imm;
        i_jal = v.jal; i_jalr = v.jalr; i_pc = v.pc; i_immediate = v.immv;
        i_rd_addr = v.rd; i_rd_we = v.we; i_mem_reg = v.mem;
        i_stg_data = v.sd; i_stg_rdy = v.rdy;
        #1;
        chk({nm, ".id_ready"}, 32'(o_id_ready), 32'(v.exp_ready));
        if (v.exp_iss) sb.push_back('{v.e_op1, v.e_op2, v.e_rs2f, v.rd, v.we, v.mem});
        @(posedge clk);
        #1;
`ifdef OP_BYPASS_STATS_EN
        exp_stall += v.st;
        exp_fwd   += v.fw;
`endif
        if (v.rst) begin
            exp_stall = 0;
            exp_fwd   = 0;
        end
        chk({nm, ".ex_valid"}, 32'(o_ex_valid), 32'(v.exp_exv));
        if (v.exp_iss) begin
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL %s.scoreboard actual=empty required=entry", nm);
            end else begin
                last = sb.pop_front();
            end
        end
        if (v.exp_exv) begin
            chk({nm, ".op1"}, o_op1, last.op1);
            chk({nm, ".op2"}, o_op2, last.op2);
            chk({nm, ".rs2_fwd"}, o_rs2_fwd, last.rs2f);
            chk({nm, ".rd"}, 32'({last.mem, last.we, o_rd_addr}),
                32'({o_mem_reg, o_rd_we, last.rd}));
        end
        if (v.rst) begin
            chk({nm, ".rst_op1"}, o_op1, 32'h0);
            chk({nm, ".rst_op2"}, o_op2, 32'h0);
        end
        chk({nm, ".stall_cnt"}, o_stall_cnt, 32'(exp_stall));
        chk({nm, ".fwd_cnt"}, o_fwd_cnt, 32'(exp_fwd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t t;
        i_rst = 1'b1; i_id_valid = 1'b0; i_ex_ready = 1'b0; i_flush = 1'b0;
        i_rs1_addr = '0; i_rs2_addr = '0; i_rs1_used = 1'b0; i_rs2_used = 1'b0;
        i_rs1_rdata = '0; i_rs2_rdata = '0; i_auipc = 1'b0; i_imm = 1'b0;
        i_jal = 1'b0; i_jalr = 1'b0; i_pc = '0; i_immediate = '0;
        i_rd_addr = '0; i_rd_we = 1'b0; i_mem_reg = 1'b0; i_stg_data = '0; i_stg_rdy = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ex_valid", 32'(o_ex_valid), 32'h0);
        chk("reset.id_ready", 32'(o_id_ready), 32'h0);
        chk("reset.op1", o_op1, 32'h0);
        chk("reset.op2", o_op2, 32'h0);
        chk("reset.rs2_fwd", o_rs2_fwd, 32'h0);
        chk("reset.rd", 32'({o_mem_reg, o_rd_we, o_rd_addr}), 32'h0);
        chk("reset.cnts", o_stall_cnt | o_fwd_cnt, 32'h0);

        t = ins(1, 1, 32'h1000, 2, 1, 32'h2000, 5, 1);
        tbl.push_back(t); names.push_back("v0_plain");
        t = ins(5, 1, 32'hDEAD, 3, 1, 32'h3, 8, 1);
        t.sd = sd3(0, 0, 32'h11); t.e_op1 = 32'h11; t.fw = 1;
        tbl.push_back(t); names.push_back("v1_back2back");
        t = ins(0, 1, 0, 4, 0, 32'h4, 0, 1);
        t.imm = 1; t.immv = 32'h77; t.e_op2 = 32'h77;
        tbl.push_back(t); names.push_back("v2_write_x0");
        t = ins(0, 1, 0, 5, 1, 32'hBAD, 7, 1);
        t.sd = sd3(32'h22, 0, 32'h55); t.e_op1 = 0; t.e_op2 = 32'h22; t.e_rs2f = 32'h22; t.fw = 1;
        tbl.push_back(t); names.push_back("v3_x0_noforward");
        t = ins(0, 0, 0, 0, 0, 32'h5, 9, 1);
        t.auipc = 1; t.pc = 32'h100; t.jal = 1; t.e_op1 = 32'h100; t.e_op2 = 32'h4;
        tbl.push_back(t); names.push_back("v4_auipc_jal");
        t = ins(0, 0, 0, 0, 0, 32'h6, 7, 1);
        t.imm = 1; t.jal = 1; t.immv = 32'h1234; t.e_op2 = 32'h1234;
        tbl.push_back(t); names.push_back("v5_imm_over_jal");
        t = ins(7, 1, 32'hF00, 9, 1, 32'hF01, 6, 1);
        t.mem = 1; t.jalr = 1; t.sd = sd3(32'h2, 32'h9, 32'h1);
        t.e_op1 = 32'h1; t.e_op2 = 32'h4; t.e_rs2f = 32'h9; t.fw = 2;
        tbl.push_back(t); names.push_back("v6_youngest_jalr");
        t = ins(6, 1, 32'hF02, 0, 0, 32'h44, 10, 1);
        t.rdy = 3'b110; t.exp_ready = 0; t.exp_iss = 0; t.exp_exv = 0; t.st = 1;
        tbl.push_back(t); names.push_back("v7_loaduse_stall");
        t = ins(6, 1, 32'hF02, 0, 0, 32'h44, 10, 1);
        t.sd = sd3(0, 32'hABCD, 0); t.e_op1 = 32'hABCD; t.fw = 1;
        tbl.push_back(t); names.push_back("v8_loaduse_resume");
        t = ins(10, 0, 32'h1, 10, 0, 32'h2, 11, 0);
        t.rdy = 3'b000; t.sd = sd3(0, 0, 32'h5A);
        t.e_op1 = 32'h5A; t.e_op2 = 32'h5A; t.e_rs2f = 32'h5A;
        tbl.push_back(t); names.push_back("v9_unused_nohazard");
        t = ins(1, 1, 32'h1, 2, 1, 32'h2, 12, 1);
        t.valid = 0; t.exp_iss = 0; t.exp_exv = 0;
        tbl.push_back(t); names.push_back("v10_idle");

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], names[i]);

        // Hold while EX is busy
        t = ins(1, 1, 32'hA1, 2, 1, 32'hA2, 12, 1);
        apply(t, "a1_issue");
        t = ins(3, 1, 32'hB1, 4, 1, 32'hB2, 13, 1);
        t.exr = 0; t.exp_ready = 0; t.exp_iss = 0; t.exp_exv = 1;
        apply(t, "a2_hold");
        t = ins(3, 1, 32'hB1, 4, 1, 32'hB2, 13, 1);
        t.mem = 1;
        apply(t, "a3_release");

        // Flush while stalled, then flush of a ready instruction
        t = ins(13, 1, 32'hC1, 0, 0, 32'hC2, 14, 1);
        t.rdy = 3'b000; t.flush = 1; t.exp_ready = 0; t.exp_iss = 0; t.exp_exv = 0; t.st = 1;
        apply(t, "b1_flush_stall");
        t = ins(1, 1, 32'h5, 0, 0, 32'h6, 15, 1);
        t.flush = 1; t.exp_iss = 0; t.exp_exv = 0;
        apply(t, "b2_flush_ready");

        // Load walks through all three slots: three stall cycles
        t = ins(0, 0, 32'h7, 0, 0, 32'h8, 14, 1);
        t.mem = 1;
        apply(t, "c1_load");
        for (int i = 0; i < 3; i++) begin
            t = ins(14, 1, 32'h999, 0, 0, 32'h3, 16, 1);
            t.rdy = 3'b000; t.exp_ready = 0; t.exp_iss = 0; t.exp_exv = 0; t.st = 1;
            apply(t, $sformatf("c%0d_stall", i + 2));
        end
        t = ins(14, 1, 32'h999, 0, 0, 32'h3, 16, 1);
        t.rdy = 3'b000;
        apply(t, "c5_drained");

        // Reset in the middle of a load-use stall
        t = ins(0, 0, 32'h1, 0, 0, 32'h2, 15, 1);
        t.mem = 1;
        apply(t, "d1_load");
        t = ins(15, 1, 32'h3, 0, 0, 32'h4, 17, 1);
        t.rdy = 3'b000; t.rst = 1; t.exp_ready = 0; t.exp_iss = 0; t.exp_exv = 0;
        apply(t, "d2_reset_stall");
        t = ins(15, 1, 32'h3, 0, 0, 32'h4, 17, 1);
        t.rdy = 3'b000;
        apply(t, "d3_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
